// File: rtl/mips_instr_encoder_if.sv
// Request/write bundle for mips_instr_encoder.
// master drives requests + wr_ready; slave is the encoder.
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err_illegal;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd,
    output in_shamt, in_funct, in_imm, in_target,
    output wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data,
    input  count, full, err_illegal
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd,
    input  in_shamt, in_funct, in_imm, in_target,
    input  wr_ready,
    output in_ready, wr_en, wr_addr, wr_data,
    output count, full, err_illegal
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Field-level MIPS request -> 32-bit word, written sequentially
// to instruction memory. Ports: clk, reset (async, high), clear
// (sync flush/rewind), bus (slave): in_* request with valid/ready,
// wr_* memory write with backpressure, count, full, err_illegal.
module mips_instr_encoder #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  mips_instr_encoder_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C =
    ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_C =
    ADDR_W'(BASE_ADDR + DEPTH - 1);

  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   count_q,   count_d;
  logic              err_q,     err_d;

  logic        full;
  logic        in_ready;
  logic        accept;
  logic        commit;
  logic        legal;
  logic [31:0] word;

  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (bus.in_kind)
      4'd0: word = {6'h00, bus.in_rs, bus.in_rt,
                    bus.in_rd, bus.in_shamt,
                    bus.in_funct};
      4'd1: word = {6'h08, bus.in_rs, bus.in_rt,
                    bus.in_imm};
      4'd2: word = {6'h0D, bus.in_rs, bus.in_rt,
                    bus.in_imm};
      4'd3: word = {6'h0F, 5'd0, bus.in_rt,
                    bus.in_imm};
      4'd4: word = {6'h04, bus.in_rs, bus.in_rt,
                    bus.in_imm};
      4'd5: word = {6'h05, bus.in_rs, bus.in_rt,
                    bus.in_imm};
      4'd6: word = {6'h0C, bus.in_rs, bus.in_rt,
                    bus.in_imm};
      4'd7: word = {6'h23, bus.in_rs, bus.in_rt,
                    bus.in_imm};
      4'd8: word = {6'h2B, bus.in_rs, bus.in_rt,
                    bus.in_imm};
      4'd9: word = {6'h02, bus.in_target};
      default: legal = 1'b0;
    endcase
  end

  // The pending word counts toward capacity so that no request
  // is accepted once every slot is committed or in flight.
  assign full = (count_q + {{ADDR_W{1'b0}}, wr_en_q})
                == DEPTH_C;
  assign in_ready = !full && !clear
                    && (!wr_en_q || bus.wr_ready);
  assign accept = bus.in_valid && in_ready;
  assign commit = wr_en_q && bus.wr_ready;

  always_comb begin
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    err_d     = 1'b0;
    if (clear) begin
      wr_en_d   = 1'b0;
      wr_addr_d = BASE_C;
      count_d   = '0;
    end else begin
      if (commit) begin
        wr_en_d = 1'b0;
        count_d = count_q + (ADDR_W+1)'(1);
        // Address parks on the last slot instead of wrapping.
        if (wr_addr_q != LAST_C)
          wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
      if (accept) begin
        if (legal) begin
          wr_en_d   = 1'b1;
          wr_data_d = word;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_C;
      wr_data_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.err_illegal = err_q;

endmodule
